// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths and FSM encoding for the sequential CORDIC arbiter
package cordic_pkg;

    localparam int DATA_W = 34;
    localparam int OUT_W  = 32;
    localparam int ITER_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_iter_stage.sv
// rtl/cordic_iter_stage.sv - one combinational vectoring micro-rotation
//
// Ports:
//   x, y           current vector (signed, DATA_W bits)
//   shift          arithmetic right-shift amount for this rotation (0..32)
//   x_next, y_next rotated vector; rotation direction drives y towards zero
module cordic_iter_stage
    import cordic_pkg::*;
(
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic        [ITER_W-1:0] shift,
    output logic signed [DATA_W-1:0] x_next,
    output logic signed [DATA_W-1:0] y_next
);

    logic signed [DATA_W-1:0] x_sh;
    logic signed [DATA_W-1:0] y_sh;

    assign x_sh = x >>> shift;
    assign y_sh = y >>> shift;

    // Negative y rotates counter-clockwise, otherwise clockwise; both
    // updates use the pre-rotation values and wrap at DATA_W bits.
    assign x_next = y[DATA_W-1] ? (x + y_sh) : (x - y_sh);
    assign y_next = y[DATA_W-1] ? (y + x_sh) : (y - x_sh);

endmodule

// File: rtl/cordic_seq_arb.sv
// rtl/cordic_seq_arb.sv - two-port round-robin front end for an iterative vectoring CORDIC
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req0_*/req1_*                operand handshakes (valid/ready, ix/iy)
//   rsp0_valid/rsp1_valid        result held for the owning requester
//   rsp0_ready/rsp1_ready        requester takes the result
//   rsp_ox, rsp_oy               result, shared by both response ports
//   busy                         high whenever an operation is in flight
module cordic_seq_arb
    import cordic_pkg::*;
#(
    parameter int ITERATION = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic signed [DATA_W-1:0] req0_ix,
    input  logic signed [DATA_W-1:0] req0_iy,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic signed [DATA_W-1:0] req1_ix,
    input  logic signed [DATA_W-1:0] req1_iy,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic        [OUT_W-1:0]  rsp_ox,
    output logic        [OUT_W-1:0]  rsp_oy,
    output logic                     busy
);

    localparam logic [ITER_W-1:0] LAST_I = ITER_W'(ITERATION - 1);

    state_t                   state;
    state_t                   state_next;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] x_rot;
    logic signed [DATA_W-1:0] y_rot;
    logic        [ITER_W-1:0] i;
    logic                     owner;
    logic                     prio;
    logic                     grant;
    logic                     accept;
    logic                     owner_ready;

    // Port 1 wins when it is alone or when both request and it holds priority.
    assign grant       = (req0_valid & req1_valid) ? prio : req1_valid;
    assign accept      = (state == ST_IDLE) & (req0_valid | req1_valid);
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    cordic_iter_stage u_stage (
        .x      (x),
        .y      (y),
        .shift  (i + ITER_W'(1)),
        .x_next (x_rot),
        .y_next (y_rot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = ST_RUN;
            ST_RUN:  if (i == LAST_I)   state_next = ST_DONE;
            ST_DONE: if (owner_ready)   state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == ST_IDLE) & req0_valid & ~grant;
        req1_ready = (state == ST_IDLE) & req1_valid & grant;
        rsp0_valid = (state == ST_DONE) & ~owner;
        rsp1_valid = (state == ST_DONE) & owner;
        busy       = (state != ST_IDLE);
        rsp_ox     = x[OUT_W-1:0];
        rsp_oy     = y[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            i     <= '0;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else if (accept) begin
            x     <= grant ? req1_ix : req0_ix;
            y     <= grant ? req1_iy : req0_iy;
            i     <= '0;
            owner <= grant;
            prio  <= ~grant;
        end else if (state == ST_RUN) begin
            x <= x_rot;
            y <= y_rot;
            i <= i + ITER_W'(1);
        end
    end

endmodule

// File: tb/tb_cordic_seq_arb.sv
// tb/tb_cordic_seq_arb.sv - self-checking bench for cordic_seq_arb at ITERATION 1, 2 and 32
module tb_cordic_seq_arb;

    localparam int NI = 3;
    localparam int ITERS [NI] = '{1, 2, 32};

    logic        clk;
    logic        rst;
    logic        rv  [NI][2];
    logic        rr  [NI][2];
    logic [33:0] rix [NI][2];
    logic [33:0] riy [NI][2];
    logic        sv  [NI][2];
    logic        sr  [NI][2];
    logic [31:0] ox  [NI];
    logic [31:0] oy  [NI];
    logic        bsy [NI];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cordic_seq_arb #(.ITERATION(ITERS[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (rv[g][0]),
            .req0_ready (rr[g][0]),
            .req0_ix    (rix[g][0]),
            .req0_iy    (riy[g][0]),
            .req1_valid (rv[g][1]),
            .req1_ready (rr[g][1]),
            .req1_ix    (rix[g][1]),
            .req1_iy    (riy[g][1]),
            .rsp0_valid (sv[g][0]),
            .rsp0_ready (sr[g][0]),
            .rsp1_valid (sv[g][1]),
            .rsp1_ready (sr[g][1]),
            .rsp_ox     (ox[g]),
            .rsp_oy     (oy[g]),
            .busy       (bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: n vectoring rotations on 34-bit wrapping values, truncated to 32 bits.
    function automatic logic [63:0] cordic_ref(input logic signed [33:0] ix,
                                               input logic signed [33:0] iy,
                                               input int n);
        logic signed [33:0] xv;
        logic signed [33:0] yv;
        logic signed [33:0] xo;
        xv = ix;
        yv = iy;
        for (int k = 0; k < n; k++) begin
            xo = xv;
            if (yv < 0) begin
                xv = xv + (yv >>> (k + 1));
                yv = yv + (xo >>> (k + 1));
            end else begin
                xv = xv - (yv >>> (k + 1));
                yv = yv - (xo >>> (k + 1));
            end
        end
        return {xv[31:0], yv[31:0]};
    endfunction

    function automatic logic [33:0] rnd34();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[33:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE on instance k, port p; holds the result stall
    // cycles with rsp_ready low while the other port keeps requesting.
    task automatic do_op(input int k, input int p, input logic [33:0] ix,
                         input logic [33:0] iy, input int stall,
                         output logic [31:0] got_x, output logic [31:0] got_y);
        logic [63:0] exp;
        int          n;
        int          q;
        q   = 1 - p;
        exp = cordic_ref(ix, iy, ITERS[k]);
        rix[k][p] = ix;
        riy[k][p] = iy;
        rv[k][p]  = 1'b1;
        #1;
        checks++;
        if (rr[k][p] !== 1'b1) begin
            failures++;
            $error("FAIL req_ready_idle observed=%0h expected=%0h", rr[k][p], 1'b1);
        end
        tick();
        rv[k][p] = 1'b0;
        n = 0;
        while (!sv[k][p] && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== ITERS[k]) begin
            failures++;
            $error("FAIL latency observed=%0h expected=%0h", n, ITERS[k]);
        end
        checks++;
        if (sv[k][q] !== 1'b0) begin
            failures++;
            $error("FAIL rsp_other_low observed=%0h expected=%0h", sv[k][q], 1'b0);
        end
        checks++;
        if (bsy[k] !== 1'b1) begin
            failures++;
            $error("FAIL busy_done observed=%0h expected=%0h", bsy[k], 1'b1);
        end
        checks++;
        if (ox[k] !== exp[63:32]) begin
            failures++;
            $error("FAIL rsp_ox observed=%0h expected=%0h", ox[k], exp[63:32]);
        end
        checks++;
        if (oy[k] !== exp[31:0]) begin
            failures++;
            $error("FAIL rsp_oy observed=%0h expected=%0h", oy[k], exp[31:0]);
        end
        got_x = ox[k];
        got_y = oy[k];
        if (stall > 0) begin
            rix[k][q] = rnd34();
            riy[k][q] = rnd34();
            rv[k][q]  = 1'b1;
            sr[k][q]  = 1'b1;
            for (int s = 0; s < stall; s++) begin
                tick();
                checks++;
                if (sv[k][p] !== 1'b1) begin
                    failures++;
                    $error("FAIL stall_valid observed=%0h expected=%0h", sv[k][p], 1'b1);
                end
                checks++;
                if (ox[k] !== exp[63:32]) begin
                    failures++;
                    $error("FAIL stall_ox observed=%0h expected=%0h", ox[k], exp[63:32]);
                end
                checks++;
                if (oy[k] !== exp[31:0]) begin
                    failures++;
                    $error("FAIL stall_oy observed=%0h expected=%0h", oy[k], exp[31:0]);
                end
                checks++;
                if (rr[k][q] !== 1'b0) begin
                    failures++;
                    $error("FAIL stall_no_accept observed=%0h expected=%0h", rr[k][q], 1'b0);
                end
                checks++;
                if (bsy[k] !== 1'b1) begin
                    failures++;
                    $error("FAIL stall_busy observed=%0h expected=%0h", bsy[k], 1'b1);
                end
            end
            rv[k][q] = 1'b0;
            sr[k][q] = 1'b0;
        end
        sr[k][p] = 1'b1;
        tick();
        sr[k][p] = 1'b0;
        checks++;
        if (bsy[k] !== 1'b0) begin
            failures++;
            $error("FAIL idle_after_take observed=%0h expected=%0h", bsy[k], 1'b0);
        end
        checks++;
        if (sv[k][p] !== 1'b0) begin
            failures++;
            $error("FAIL rsp_valid_cleared observed=%0h expected=%0h", sv[k][p], 1'b0);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] gx;
        logic [31:0] gy;
        logic [63:0] exp;
        int          n;
        int          g;
        int          k;
        int          seen;
        time         t_acc;
        time         t_prev;

        rst = 1'b1;
        for (int a = 0; a < NI; a++) begin
            for (int b = 0; b < 2; b++) begin
                rv[a][b]  = 1'b0;
                sr[a][b]  = 1'b0;
                rix[a][b] = '0;
                riy[a][b] = '0;
            end
        end
        tick();
        tick();
        for (int a = 0; a < NI; a++) begin
            checks++;
            if (bsy[a] !== 1'b0) begin
                failures++;
                $error("FAIL reset_busy observed=%0h expected=%0h", bsy[a], 1'b0);
            end
            checks++;
            if (sv[a][0] !== 1'b0) begin
                failures++;
                $error("FAIL reset_rsp0 observed=%0h expected=%0h", sv[a][0], 1'b0);
            end
            checks++;
            if (sv[a][1] !== 1'b0) begin
                failures++;
                $error("FAIL reset_rsp1 observed=%0h expected=%0h", sv[a][1], 1'b0);
            end
            checks++;
            if (ox[a] !== 32'h0) begin
                failures++;
                $error("FAIL reset_ox observed=%0h expected=%0h", ox[a], 32'h0);
            end
            checks++;
            if (oy[a] !== 32'h0) begin
                failures++;
                $error("FAIL reset_oy observed=%0h expected=%0h", oy[a], 32'h0);
            end
        end
        rst = 1'b0;
        tick();

        // Directed vectors at ITERATION 1 and 2.
        do_op(0, 0, 34'd100, 34'd50, 0, gx, gy);
        checks++;
        if (gx !== 32'd75) begin
            failures++;
            $error("FAIL it1_ox observed=%0h expected=%0h", gx, 32'd75);
        end
        checks++;
        if (gy !== 32'd0) begin
            failures++;
            $error("FAIL it1_oy observed=%0h expected=%0h", gy, 32'd0);
        end
        do_op(1, 0, 34'd100, 34'd50, 0, gx, gy);
        checks++;
        if (gx !== 32'd75) begin
            failures++;
            $error("FAIL it2_ox observed=%0h expected=%0h", gx, 32'd75);
        end
        checks++;
        if (gy !== 32'hFFFF_FFEE) begin
            failures++;
            $error("FAIL it2_oy observed=%0h expected=%0h", gy, 32'hFFFF_FFEE);
        end
        do_op(0, 1, 34'd100, -34'sd40, 0, gx, gy);
        checks++;
        if (gx !== 32'd80) begin
            failures++;
            $error("FAIL it1_p1_ox observed=%0h expected=%0h", gx, 32'd80);
        end
        checks++;
        if (gy !== 32'd10) begin
            failures++;
            $error("FAIL it1_p1_oy observed=%0h expected=%0h", gy, 32'd10);
        end

        // Random operands on every instance, random port and stall length.
        for (int r = 0; r < 9; r++) begin
            do_op(r % NI, int'($urandom_range(0, 1)), rnd34(), rnd34(),
                  int'($urandom_range(0, 3)), gx, gy);
        end

        // Result held for five cycles while the other port requests.
        do_op(2, 0, rnd34(), rnd34(), 5, gx, gy);

        // Both ports requesting continuously from reset: alternating grants.
        k = 1;
        pulse_reset();
        t_prev = 0;
        for (int b = 0; b < 2; b++) begin
            rix[k][b] = rnd34();
            riy[k][b] = rnd34();
            rv[k][b]  = 1'b1;
            sr[k][b]  = 1'b1;
        end
        #1;
        for (int op = 0; op < 6; op++) begin
            n = 0;
            while (!(rr[k][0] | rr[k][1]) && n < 50) begin
                tick();
                n++;
            end
            checks++;
            if ((rr[k][0] | rr[k][1]) !== 1'b1) begin
                failures++;
                $error("FAIL rr_grant_seen observed=%0h expected=%0h", rr[k][0] | rr[k][1], 1'b1);
            end
            g = rr[k][1] ? 1 : 0;
            checks++;
            if (g !== op % 2) begin
                failures++;
                $error("FAIL rr_grant_order observed=%0h expected=%0h", g, op % 2);
            end
            exp = cordic_ref(rix[k][g], riy[k][g], ITERS[k]);
            @(posedge clk);
            t_acc = $time;
            #1;
            if (op > 0) begin
                checks++;
                if ((t_acc - t_prev) !== time'((ITERS[k] + 2) * 10)) begin
                    failures++;
                    $error("FAIL rr_period observed=%0d expected=%0d", t_acc - t_prev, (ITERS[k] + 2) * 10);
                end
            end
            t_prev = t_acc;
            rix[k][g] = rnd34();
            riy[k][g] = rnd34();
            n = 0;
            while (!sv[k][g] && n < 50) begin
                tick();
                n++;
            end
            checks++;
            if (n !== ITERS[k]) begin
                failures++;
                $error("FAIL rr_latency observed=%0h expected=%0h", n, ITERS[k]);
            end
            checks++;
            if (sv[k][1 - g] !== 1'b0) begin
                failures++;
                $error("FAIL rr_other_low observed=%0h expected=%0h", sv[k][1 - g], 1'b0);
            end
            checks++;
            if (ox[k] !== exp[63:32]) begin
                failures++;
                $error("FAIL rr_ox observed=%0h expected=%0h", ox[k], exp[63:32]);
            end
            checks++;
            if (oy[k] !== exp[31:0]) begin
                failures++;
                $error("FAIL rr_oy observed=%0h expected=%0h", oy[k], exp[31:0]);
            end
        end
        for (int b = 0; b < 2; b++) begin
            rv[k][b] = 1'b0;
            sr[k][b] = 1'b0;
        end
        tick();
        tick();

        // Reset in the middle of a 32-iteration run.
        k = 2;
        rix[k][0] = rnd34();
        riy[k][0] = rnd34();
        rv[k][0]  = 1'b1;
        sr[k][0]  = 1'b1;
        sr[k][1]  = 1'b1;
        tick();
        rv[k][0] = 1'b0;
        for (int s = 0; s < 10; s++) tick();
        checks++;
        if (bsy[k] !== 1'b1) begin
            failures++;
            $error("FAIL midrun_busy observed=%0h expected=%0h", bsy[k], 1'b1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bsy[k] !== 1'b0) begin
            failures++;
            $error("FAIL abort_busy observed=%0h expected=%0h", bsy[k], 1'b0);
        end
        checks++;
        if (sv[k][0] !== 1'b0) begin
            failures++;
            $error("FAIL abort_rsp0 observed=%0h expected=%0h", sv[k][0], 1'b0);
        end
        checks++;
        if (sv[k][1] !== 1'b0) begin
            failures++;
            $error("FAIL abort_rsp1 observed=%0h expected=%0h", sv[k][1], 1'b0);
        end
        checks++;
        if (ox[k] !== 32'h0) begin
            failures++;
            $error("FAIL abort_ox observed=%0h expected=%0h", ox[k], 32'h0);
        end
        checks++;
        if (oy[k] !== 32'h0) begin
            failures++;
            $error("FAIL abort_oy observed=%0h expected=%0h", oy[k], 32'h0);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int s = 0; s < ITERS[k] + 5; s++) begin
            tick();
            if (sv[k][0] || sv[k][1] || bsy[k]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $error("FAIL abort_no_response observed=%0h expected=%0h", seen, 0);
        end
        sr[k][0] = 1'b0;
        sr[k][1] = 1'b0;
        do_op(k, 1, rnd34(), rnd34(), 0, gx, gy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
